// File: rtl/tile_scheduler_pkg.sv
// tile_scheduler_pkg: shared controller types for the layer tile sequencer.
// Holds layer-type codes, the scheduler state enum and the tile descriptor struct.
package tile_scheduler_pkg;
    localparam int SCHED_N_W = 16;
    localparam int SCHED_C_W = 8;

    typedef enum logic [1:0] {
        POINTWISE = 2'd0,
        DEPTHWISE = 2'd1,
        STANDARD  = 2'd2,
        LINEAR    = 2'd3
    } layer_type_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_C_W-1:0] d_base;
        logic [SCHED_C_W-1:0] k_base;
        logic [SCHED_N_W-1:0] n_base;
        logic [SCHED_C_W-1:0] d_size;
        logic [SCHED_C_W-1:0] k_size;
        logic [SCHED_N_W-1:0] n_size;
        logic                 first_d;
        logic                 last_d;
    } tile_desc_t;
endpackage

// File: rtl/tile_axis_cnt.sv
// tile_axis_cnt: one tiling axis - base index, remainder-clipped size and wrap flag.
// Ports: clk, rst (sync, active-high), clr (zero base), adv (step or wrap base),
//        step/limit (tile size, axis extent), base/size (current tile), wrap (last tile on axis).
module tile_axis_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    output logic [W-1:0] base,
    output logic [W-1:0] size,
    output logic         wrap
);
    logic [W:0]   sum;
    logic [W-1:0] rem;

    // One extra bit so base+step near the top of the range cannot alias back.
    assign sum  = {1'b0, base} + {1'b0, step};
    assign wrap = sum >= {1'b0, limit};
    assign rem  = limit - base;
    assign size = (rem < step) ? rem : step;

    always_ff @(posedge clk) begin
        if (rst || clr)
            base <= '0;
        else if (adv)
            base <= wrap ? '0 : sum[W-1:0];
    end
endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks the (n, k, d) tile space of a layer, issuing one descriptor at a time.
// Ports: clk, rst (sync, active-high); start + layer config (layer_type, in_C, out_C, total_n,
//        tile_D, tile_K, tile_n) latched on start; busy; tile_valid/tile_ready handshake with
//        descriptor (d/k/n base and size, first_d, last_d); tile_done from launcher;
//        layer_done pulse; sticky cfg_err.
module tile_scheduler
    import tile_scheduler_pkg::*;
#(
    parameter int N_W = SCHED_N_W,
    parameter int C_W = SCHED_C_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     layer_type,
    input  logic [C_W-1:0] in_C,
    input  logic [C_W-1:0] out_C,
    input  logic [N_W-1:0] total_n,
    input  logic [C_W-1:0] tile_D,
    input  logic [C_W-1:0] tile_K,
    input  logic [31:0]    tile_n,
    output logic           busy,
    output logic           tile_valid,
    input  logic           tile_ready,
    output logic [C_W-1:0] d_base,
    output logic [C_W-1:0] k_base,
    output logic [N_W-1:0] n_base,
    output logic [C_W-1:0] d_size,
    output logic [C_W-1:0] k_size,
    output logic [N_W-1:0] n_size,
    output logic           first_d,
    output logic           last_d,
    input  logic           tile_done,
    output logic           layer_done,
    output logic           cfg_err
);
    sched_state_t   state, next;
    layer_type_t    lt_q;
    logic [C_W-1:0] in_c_q, out_c_q, tile_d_q, tile_k_q;
    logic [N_W-1:0] total_n_q, tile_n_q, tn_sat, tn_eff;
    logic [C_W-1:0] d_b, d_s, k_b, k_s;
    logic [N_W-1:0] n_b, n_s;
    logic           d_wrap, k_wrap, n_wrap, d_wrap_e, dw, cfg_bad, accept, done_ev, last;
    tile_desc_t     desc;

    // Oversized tile_n saturates; PW needs groups of 4 spatial positions.
    assign tn_sat = |tile_n[31:N_W] ? '1 : tile_n[N_W-1:0];
    assign tn_eff = (layer_type == POINTWISE) ? {tn_sat[N_W-1:2], 2'b00} : tn_sat;

    assign accept   = (state == IDLE) && start;
    assign dw       = (lt_q == DEPTHWISE);
    assign d_wrap_e = dw || d_wrap;
    assign done_ev  = (state == WAIT) && tile_done;
    assign last     = d_wrap_e && k_wrap && n_wrap;
    // tile_D is irrelevant for DW because the d loop follows k.
    assign cfg_bad  = (in_c_q == '0) || (out_c_q == '0) || (total_n_q == '0) ||
                      (tile_k_q == '0) || (tile_n_q == '0) || (!dw && tile_d_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            lt_q      <= POINTWISE;
            in_c_q    <= '0;
            out_c_q   <= '0;
            total_n_q <= '0;
            tile_d_q  <= '0;
            tile_k_q  <= '0;
            tile_n_q  <= '0;
        end else if (accept) begin
            lt_q      <= layer_type_t'(layer_type);
            in_c_q    <= in_C;
            out_c_q   <= out_C;
            total_n_q <= total_n;
            tile_d_q  <= tile_D;
            tile_k_q  <= tile_K;
            tile_n_q  <= tn_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept)
            cfg_err <= 1'b0;
        else if (state == CHECK && cfg_bad)
            cfg_err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next       = state;
        busy       = (state != IDLE);
        tile_valid = (state == ISSUE);
        layer_done = (state == DONE);
        case (state)
            IDLE:    if (start) next = CHECK;
            CHECK:   next = cfg_bad ? DONE : ISSUE;
            ISSUE:   if (tile_ready) next = WAIT;
            WAIT:    if (tile_done) next = last ? DONE : ISSUE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    tile_axis_cnt #(.W(C_W)) u_d (
        .clk(clk), .rst(rst), .clr(state == CHECK), .adv(done_ev),
        .step(tile_d_q), .limit(in_c_q), .base(d_b), .size(d_s), .wrap(d_wrap)
    );

    tile_axis_cnt #(.W(C_W)) u_k (
        .clk(clk), .rst(rst), .clr(state == CHECK), .adv(done_ev && d_wrap_e),
        .step(tile_k_q), .limit(out_c_q), .base(k_b), .size(k_s), .wrap(k_wrap)
    );

    tile_axis_cnt #(.W(N_W)) u_n (
        .clk(clk), .rst(rst), .clr(state == CHECK), .adv(done_ev && d_wrap_e && k_wrap),
        .step(tile_n_q), .limit(total_n_q), .base(n_b), .size(n_s), .wrap(n_wrap)
    );

    // Descriptor comes straight from the base registers, which only move in WAIT,
    // so it is stable for the whole ISSUE phase; it reads as zero otherwise.
    always_comb begin
        desc = '0;
        if (tile_valid) begin
            desc.d_base  = dw ? k_b : d_b;
            desc.k_base  = k_b;
            desc.n_base  = n_b;
            desc.d_size  = dw ? k_s : d_s;
            desc.k_size  = k_s;
            desc.n_size  = n_s;
            desc.first_d = dw || (d_b == '0);
            desc.last_d  = d_wrap_e;
        end
    end

    assign d_base  = desc.d_base;
    assign k_base  = desc.k_base;
    assign n_base  = desc.n_base;
    assign d_size  = desc.d_size;
    assign k_size  = desc.k_size;
    assign n_size  = desc.n_size;
    assign first_d = desc.first_d;
    assign last_d  = desc.last_d;
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: directed self-checking bench for tile_scheduler.
module tb_tile_scheduler;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [1:0]  layer_type = 0;
    logic [7:0]  in_C = 0, out_C = 0, tile_D = 0, tile_K = 0;
    logic [15:0] total_n = 0;
    logic [31:0] tile_n = 0;
    logic        busy, tile_valid, tile_ready = 0, tile_done = 0, layer_done, cfg_err;
    logic [7:0]  d_base, k_base, d_size, k_size;
    logic [15:0] n_base, n_size;
    logic        first_d, last_d;
    logic [65:0] cur;
    logic [65:0] got [64];
    int          ntiles, lat_err, stall_err, ld_count = 0;
    int          checks = 0, errors = 0;

    tile_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .layer_type(layer_type),
        .in_C(in_C), .out_C(out_C), .total_n(total_n), .tile_D(tile_D), .tile_K(tile_K),
        .tile_n(tile_n), .busy(busy), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .d_base(d_base), .k_base(k_base), .n_base(n_base), .d_size(d_size), .k_size(k_size),
        .n_size(n_size), .first_d(first_d), .last_d(last_d), .tile_done(tile_done),
        .layer_done(layer_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    assign cur = {d_base, k_base, n_base, d_size, k_size, n_size, first_d, last_d};

    always @(negedge clk) if (layer_done) ld_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [65:0] mk(int d, int k, int n, int ds, int ks, int ns, bit f, bit l);
        return {8'(d), 8'(k), 16'(n), 8'(ds), 8'(ks), 16'(ns), f, l};
    endfunction

    // PW reference layer: in_C=64, out_C=32, total_n=10, tile_D=32, tile_K=16, tile_n=4.
    function automatic logic [65:0] pw_exp(int i);
        int n, k, d;
        n = (i / 4) * 4;
        k = ((i / 2) % 2) * 16;
        d = (i % 2) * 32;
        return mk(d, k, n, 32, 16, (10 - n < 4) ? 10 - n : 4, d == 0, d == 32);
    endfunction

    task automatic cfg(logic [1:0] lt, int ic, int oc, int tn, int td, int tk, int tnn);
        layer_type = lt; in_C = 8'(ic); out_C = 8'(oc); total_n = 16'(tn);
        tile_D = 8'(td); tile_K = 8'(tk); tile_n = 32'(tnn);
    endtask

    task automatic go();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    // Drives the launcher side until layer_done, recording every descriptor seen.
    task automatic run_tiles(input int bp_idx, input bit spur);
        int  t;
        bit  ended;
        logic [65:0] held;
        ntiles = 0; ended = 0; lat_err = 0; stall_err = 0;
        for (int i = 0; i < 64; i++) got[i] = 'x;
        while (!ended && ntiles < 64) begin
            tile_ready = (ntiles != bp_idx);
            t = 0;
            while (!tile_valid && !layer_done && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (layer_done) ended = 1;
            else if (!tile_valid) begin
                checks++; errors++;
                $display("FAIL tile_wait: tile_valid=%0b after %0d cycles, required 1", tile_valid, t);
                return;
            end else begin
                got[ntiles] = cur;
                held = cur;
                if (ntiles == bp_idx) begin
                    for (int c = 0; c < 5; c++) begin
                        tile_done = spur && (c == 1);
                        start     = spur && (c == 1);
                        @(negedge clk);
                        if (!tile_valid || cur !== held) stall_err++;
                    end
                    tile_done = 0; start = 0; tile_ready = 1;
                end
                @(negedge clk);
                if (tile_valid) lat_err++;
                if (spur) start = 1;
                @(negedge clk);
                start = 0;
                @(negedge clk);
                @(negedge clk);
                tile_done = 1;
                @(negedge clk);
                tile_done = 0;
                ntiles++;
                if (!tile_valid && !layer_done) lat_err++;
            end
        end
        tile_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, tile_valid, cur, layer_done, cfg_err} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h, required 0", {busy, tile_valid, cur, layer_done, cfg_err}); end
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL reset_idle: busy=%0b, required 0", busy); end
    endtask

    task automatic test_pw();
        int n0;
        n0 = ld_count;
        cfg(0, 64, 32, 10, 32, 16, 4);
        go();
        checks++;
        if (busy !== 1) begin errors++; $display("FAIL pw_busy: busy=%0b, required 1", busy); end
        run_tiles(-1, 0);
        checks++;
        if (ntiles !== 12) begin errors++; $display("FAIL pw_count: got %0d tiles, required 12", ntiles); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] !== pw_exp(i)) begin errors++; $display("FAIL pw_tile%0d: got %h, required %h", i, got[i], pw_exp(i)); end
        end
        checks++;
        if (got[0][1] !== 1'b1 || got[0][65:34] !== '0)
            begin errors++; $display("FAIL pw_first: got %h, required d0 k0 n0 first_d=1", got[0]); end
        checks++;
        if (got[1][65:58] !== 8'd32 || got[1][0] !== 1'b1)
            begin errors++; $display("FAIL pw_second: d_base=%0d last_d=%0b, required 32 and 1", got[1][65:58], got[1][0]); end
        checks++;
        if (got[11][49:34] !== 16'd8 || got[11][17:2] !== 16'd2 || got[11][57:50] !== 8'd16 || got[11][65:58] !== 8'd32)
            begin errors++; $display("FAIL pw_final: got %h, required n8 ns2 k16 d32", got[11]); end
        checks++;
        if (lat_err !== 0) begin errors++; $display("FAIL pw_latency: %0d handshake timing errors, required 0", lat_err); end
        @(negedge clk);
        checks++;
        if (ld_count - n0 !== 1) begin errors++; $display("FAIL pw_layer_done: %0d pulses, required 1", ld_count - n0); end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL pw_busy_end: busy=%0b, required 0", busy); end
    endtask

    task automatic test_backpressure();
        cfg(0, 64, 32, 10, 32, 16, 4);
        go();
        run_tiles(3, 0);
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stall_err); end
        checks++;
        if (ntiles !== 12) begin errors++; $display("FAIL bp_count: got %0d tiles, required 12", ntiles); end
        for (int i = 2; i < 5; i++) begin
            checks++;
            if (got[i] !== pw_exp(i)) begin errors++; $display("FAIL bp_tile%0d: got %h, required %h", i, got[i], pw_exp(i)); end
        end
        checks++;
        if (lat_err !== 0) begin errors++; $display("FAIL bp_latency: %0d handshake timing errors, required 0", lat_err); end
        @(negedge clk);
    endtask

    task automatic test_dw();
        logic [65:0] e;
        cfg(1, 20, 20, 5, 3, 8, 5);
        go();
        run_tiles(-1, 0);
        checks++;
        if (ntiles !== 3) begin errors++; $display("FAIL dw_count: got %0d tiles, required 3", ntiles); end
        for (int i = 0; i < 3; i++) begin
            e = mk(i * 8, i * 8, 0, (i == 2) ? 4 : 8, (i == 2) ? 4 : 8, 5, 1, 1);
            checks++;
            if (got[i] !== e) begin errors++; $display("FAIL dw_tile%0d: got %h, required %h", i, got[i], e); end
        end
        @(negedge clk);
    endtask

    task automatic test_cfg_err();
        int n0;
        n0 = ld_count;
        cfg(0, 64, 32, 10, 32, 16, 2);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        checks++;
        if (tile_valid !== 0 || layer_done !== 0 || busy !== 1)
            begin errors++; $display("FAIL err_check: valid=%0b done=%0b busy=%0b, required 0 0 1", tile_valid, layer_done, busy); end
        @(negedge clk);
        checks++;
        if (layer_done !== 1 || cfg_err !== 1 || tile_valid !== 0)
            begin errors++; $display("FAIL err_done: done=%0b cfg_err=%0b valid=%0b, required 1 1 0", layer_done, cfg_err, tile_valid); end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1 || busy !== 0 || layer_done !== 0)
            begin errors++; $display("FAIL err_sticky: cfg_err=%0b busy=%0b done=%0b, required 1 0 0", cfg_err, busy, layer_done); end
        checks++;
        if (ld_count - n0 !== 1) begin errors++; $display("FAIL err_pulses: %0d pulses, required 1", ld_count - n0); end
        cfg(0, 8, 8, 4, 8, 8, 4);
        go();
        checks++;
        if (cfg_err !== 0) begin errors++; $display("FAIL err_clear: cfg_err=%0b, required 0", cfg_err); end
        run_tiles(-1, 0);
        checks++;
        if (ntiles !== 1 || got[0] !== mk(0, 0, 0, 8, 8, 4, 1, 1))
            begin errors++; $display("FAIL err_recover: %0d tiles first %h, required 1 tile %h", ntiles, got[0], mk(0, 0, 0, 8, 8, 4, 1, 1)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t, n0;
        cfg(0, 64, 32, 10, 32, 16, 4);
        go();
        tile_ready = 1;
        t = 0;
        while (!tile_valid && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        tile_ready = 0;
        checks++;
        if (tile_valid !== 0 || busy !== 1)
            begin errors++; $display("FAIL mid_wait: valid=%0b busy=%0b, required 0 1", tile_valid, busy); end
        n0 = ld_count;
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if ({busy, tile_valid, cur, layer_done, cfg_err} !== '0)
            begin errors++; $display("FAIL mid_reset: got %h, required 0", {busy, tile_valid, cur, layer_done, cfg_err}); end
        tile_done = 1;
        @(negedge clk);
        tile_done = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (ld_count !== n0 || busy !== 0)
            begin errors++; $display("FAIL mid_no_done: pulses=%0d busy=%0b, required 0 0", ld_count - n0, busy); end
        go();
        run_tiles(-1, 0);
        checks++;
        if (ntiles !== 12) begin errors++; $display("FAIL mid_rerun_count: got %0d tiles, required 12", ntiles); end
        for (int i = 0; i < 12; i += 5) begin
            checks++;
            if (got[i] !== pw_exp(i)) begin errors++; $display("FAIL mid_rerun_tile%0d: got %h, required %h", i, got[i], pw_exp(i)); end
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        int n0;
        n0 = ld_count;
        tile_done = 1;
        @(negedge clk);
        tile_done = 0;
        checks++;
        if (busy !== 0 || tile_valid !== 0)
            begin errors++; $display("FAIL spur_idle: busy=%0b valid=%0b, required 0 0", busy, tile_valid); end
        cfg(0, 64, 32, 10, 32, 16, 4);
        go();
        run_tiles(2, 1);
        checks++;
        if (ntiles !== 12) begin errors++; $display("FAIL spur_count: got %0d tiles, required 12", ntiles); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] !== pw_exp(i)) begin errors++; $display("FAIL spur_tile%0d: got %h, required %h", i, got[i], pw_exp(i)); end
        end
        checks++;
        if (stall_err !== 0 || lat_err !== 0)
            begin errors++; $display("FAIL spur_timing: stall=%0d lat=%0d, required 0 0", stall_err, lat_err); end
        @(negedge clk);
        checks++;
        if (ld_count - n0 !== 1) begin errors++; $display("FAIL spur_layer_done: %0d pulses, required 1", ld_count - n0); end
    endtask

    initial begin
        test_reset();
        test_pw();
        test_backpressure();
        test_dw();
        test_cfg_err();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
